// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered before the ALU; the result is held until the owner accepts it.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTRLW = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Req0Valid,
   output logic             Req0Ready,
   input  logic [WIDTH-1:0] Req0SrcA,
   input  logic [WIDTH-1:0] Req0SrcB,
   input  logic [CTRLW-1:0] Req0Ctrl,
   input  logic             Req1Valid,
   output logic             Req1Ready,
   input  logic [WIDTH-1:0] Req1SrcA,
   input  logic [WIDTH-1:0] Req1SrcB,
   input  logic [CTRLW-1:0] Req1Ctrl,
   output logic             Rsp0Valid,
   input  logic             Rsp0Ready,
   output logic [WIDTH-1:0] Rsp0Result,
   output logic             Rsp1Valid,
   input  logic             Rsp1Ready,
   output logic [WIDTH-1:0] Rsp1Result,
   output logic [WIDTH-1:0] AluSrcA,
   output logic [WIDTH-1:0] AluSrcB,
   output logic [CTRLW-1:0] AluControl,
   input  logic [WIDTH-1:0] AluResult,
   output logic             Busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_prio, r_owner;
   logic [WIDTH-1:0] r_srca, r_srcb, r_result;
   logic [CTRLW-1:0] r_ctrl;
   logic             w_win, w_acc, w_rsp_rdy;

   // On contention Prio picks; otherwise the lone valid requester wins.
   assign w_win     = (Req0Valid && Req1Valid) ? r_prio : Req1Valid;
   assign w_acc     = Req0Valid || Req1Valid;
   assign w_rsp_rdy = r_owner ? Rsp1Ready : Rsp0Ready;

   always_comb begin
      w_state_nxt = r_state;
      Req0Ready   = 1'b0;
      Req1Ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Gated by rst_n so Ready is low while reset is held.
            Req0Ready = rst_n && Req0Valid && !w_win;
            Req1Ready = rst_n && Req1Valid && w_win;
            if (w_acc) w_state_nxt = S_EXEC;
         end
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (w_rsp_rdy) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_prio   <= 1'b0;
         r_owner  <= 1'b0;
         r_srca   <= '0;
         r_srcb   <= '0;
         r_ctrl   <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: if (w_acc) begin
               r_owner <= w_win;
               r_srca  <= w_win ? Req1SrcA : Req0SrcA;
               r_srcb  <= w_win ? Req1SrcB : Req0SrcB;
               r_ctrl  <= w_win ? Req1Ctrl : Req0Ctrl;
            end
            S_EXEC: r_result <= AluResult;
            S_RESP: if (w_rsp_rdy) r_prio <= ~r_owner;
            default: ;
         endcase
      end
   end

   // ALU inputs only change on acceptance, so they stay quiet while idle.
   assign AluSrcA    = r_srca;
   assign AluSrcB    = r_srcb;
   assign AluControl = r_ctrl;
   assign Busy       = (r_state != S_IDLE);
   assign Rsp0Valid  = (r_state == S_RESP) && !r_owner;
   assign Rsp1Valid  = (r_state == S_RESP) && r_owner;
   assign Rsp0Result = r_owner ? '0 : r_result;
   assign Rsp1Result = r_owner ? r_result : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, directed cases
// with literal expectations, then randomized traffic with withdrawals and backpressure.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_v = '0, req_rdy, rsp_v, rsp_r = 2'b11;
   logic [31:0] a [2];
   logic [31:0] b [2];
   logic [2:0]  c [2];
   logic [31:0] rsp_res [2];
   logic [31:0] alu_a, alu_b, alu_res;
   logic [2:0]  alu_c;
   logic        busy;
   int          n_chk = 0, n_err = 0;
   bit          chk_en = 0;

   always #5 clk = ~clk;

   // Reference ALU: the environment the arbiter is wired to.
   function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
      case (op)
         3'b000:  return y << 16;
         3'b001:  return x | y;
         3'b010:  return y << x[4:0];
         3'b011:  return y >> x[4:0];
         3'b110:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res = alu_f(alu_a, alu_b, alu_c);

   alu_arbiter #(.WIDTH(32), .CTRLW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .Req0Valid(req_v[0]), .Req0Ready(req_rdy[0]), .Req0SrcA(a[0]), .Req0SrcB(b[0]), .Req0Ctrl(c[0]),
      .Req1Valid(req_v[1]), .Req1Ready(req_rdy[1]), .Req1SrcA(a[1]), .Req1SrcB(b[1]), .Req1Ctrl(c[1]),
      .Rsp0Valid(rsp_v[0]), .Rsp0Ready(rsp_r[0]), .Rsp0Result(rsp_res[0]),
      .Rsp1Valid(rsp_v[1]), .Rsp1Ready(rsp_r[1]), .Rsp1Result(rsp_res[1]),
      .AluSrcA(alu_a), .AluSrcB(alu_b), .AluControl(alu_c), .AluResult(alu_res),
      .Busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // One op at most in flight; it answers once it has spent one cycle in the ALU.
   logic        m_busy = 0, m_resp = 0, m_prio = 0, m_who = 0;
   logic [31:0] m_res = '0, m_a = '0, m_b = '0;
   logic [2:0]  m_c = '0;

   function automatic int winner();
      if (req_v[0] && req_v[1]) return m_prio ? 1 : 0;
      if (req_v[0]) return 0;
      if (req_v[1]) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_resp <= 0; m_prio <= 0; m_who <= 0;
         m_res <= '0; m_a <= '0; m_b <= '0; m_c <= '0;
      end else if (!m_busy) begin
         if (winner() >= 0) begin
            m_busy <= 1; m_resp <= 0;
            m_who  <= (winner() == 1);
            m_a    <= a[winner()]; m_b <= b[winner()]; m_c <= c[winner()];
            m_res  <= alu_f(a[winner()], b[winner()], c[winner()]);
         end
      end else if (!m_resp) begin
         m_resp <= 1;
      end else if (rsp_r[m_who]) begin
         m_busy <= 0; m_resp <= 0;
         m_prio <= !m_who;
      end
   end

   always @(negedge clk) begin : cmp
      logic e_idle;
      if (chk_en) begin
         e_idle = rst_n && !m_busy;
         chk("req0_ready", req_rdy[0], e_idle && winner() == 0);
         chk("req1_ready", req_rdy[1], e_idle && winner() == 1);
         chk("busy", busy, m_busy);
         chk("rsp0_valid", rsp_v[0], m_busy && m_resp && !m_who);
         chk("rsp1_valid", rsp_v[1], m_busy && m_resp && m_who);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_ctrl", alu_c, m_c);
         if (m_busy && m_resp) chk("rsp_result", rsp_res[m_who], m_res);
         if (m_busy) chk("nonowner_result", rsp_res[!m_who], 32'd0);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic issue(input int n, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      req_v[n] = 1'b1; c[n] = op; a[n] = x; b[n] = y;
   endtask

   task automatic wait_rdy(input int n, output logic other);
      bit got = 0;
      other = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_rdy[n]) begin got = 1; other = req_rdy[1-n]; end
      end
      chk("ready_seen", got, 1);
      @(posedge clk); #1;
      req_v[n] = 1'b0;
   endtask

   task automatic wait_rsp(input int n, output int lat, output logic [31:0] res);
      bit got = 0;
      lat = 0; res = '0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_v[n]) begin got = 1; res = rsp_res[n]; end
      end
      chk("rsp_seen", got, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_v = '0; rsp_r = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_v", rsp_v, 2'b00);
      chk("rst_alu_a", alu_a, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic        o;
      int          lat, prev, nacc;
      logic [1:0]  acc;
      logic [31:0] res;
      for (int n = 0; n < 2; n++) begin a[n] = '0; b[n] = '0; c[n] = '0; end
      @(posedge clk);
      chk_en = 1;
      do_reset();

      // T1: single requester, OR
      issue(0, 3'b001, 32'h0F0F0000, 32'h0000F0F0);
      wait_rdy(0, o);
      chk("t1_other_rdy", o, 0);
      wait_rsp(0, lat, res);
      chk("t1_latency", lat, 2);
      chk("t1_result", res, 32'h0F0FF0F0);

      // T2: simultaneous requests from reset priority
      do_reset();
      issue(0, 3'b010, 32'd4, 32'd1);
      issue(1, 3'b110, 32'd3, 32'd5);
      wait_rdy(0, o);
      chk("t2_first_loser_rdy", o, 0);
      wait_rsp(0, lat, res);
      chk("t2_res0", res, 32'h10);
      @(posedge clk); #1;
      issue(0, 3'b010, 32'd4, 32'd1);
      wait_rdy(1, o);
      chk("t2_pair2_loser_rdy", o, 0);
      wait_rsp(1, lat, res);
      chk("t2_res1", res, 32'h1);
      wait_rdy(0, o);
      wait_rsp(0, lat, res);
      chk("t2_res0_again", res, 32'h10);

      // T3: response backpressure
      @(posedge clk); #1;
      rsp_r[1] = 1'b0;
      issue(1, 3'b000, 32'h55, 32'h1234);
      wait_rdy(1, o);
      issue(0, 3'b001, 32'h1, 32'h2);
      wait_rsp(1, lat, res);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("t3_hold_valid", rsp_v[1], 1);
         chk("t3_hold_result", rsp_res[1], 32'h12340000);
         chk("t3_req0_blocked", req_rdy[0], 0);
      end
      @(posedge clk); #1;
      rsp_r[1] = 1'b1;
      @(negedge clk);
      chk("t3_req0_same_cycle", req_rdy[0], 0);
      @(negedge clk);
      chk("t3_req0_next_cycle", req_rdy[0], 1);
      @(posedge clk); #1;
      req_v[0] = 1'b0;
      wait_rsp(0, lat, res);
      chk("t3_res0", res, 32'h3);

      // T4: back-to-back from Req0
      @(posedge clk); #1;
      issue(0, 3'b011, 32'd8, 32'hFF00);
      prev = -1; nacc = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (req_rdy[0]) begin
            if (prev >= 0) chk("t4_gap", cyc - prev, 3);
            prev = cyc; nacc++;
         end
         chk("t4_busy_vs_ready", busy, !req_rdy[0]);
         if (rsp_v[0]) chk("t4_result", rsp_res[0], 32'hFF);
      end
      chk("t4_accepts", nacc, 4);
      @(posedge clk); #1;
      req_v[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // T5: unsupported control code
      issue(1, 3'b101, 32'd1, 32'd2);
      wait_rdy(1, o);
      wait_rsp(1, lat, res);
      chk("t5_latency", lat, 2);
      chk("t5_result", res, 32'h0);

      // T6: reset during EXEC
      @(posedge clk); #1;
      issue(0, 3'b001, 32'hAAAA0000, 32'h5555);
      wait_rdy(0, o);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_alu_a", alu_a, 0);
      chk("t6_alu_b", alu_b, 0);
      chk("t6_alu_c", alu_c, 0);
      chk("t6_rsp_v", rsp_v, 2'b00);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t6_no_rsp0", rsp_v[0], 0);
      end
      @(posedge clk); #1;
      issue(1, 3'b001, 32'd1, 32'd2);
      wait_rdy(1, o);
      wait_rsp(1, lat, res);
      chk("t6_res1", res, 32'h3);

      // Random traffic: new ops, withdrawals, response backpressure
      acc = '0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         acc = req_rdy;
         @(posedge clk); #1;
         for (int n = 0; n < 2; n++) begin
            if (acc[n] || !req_v[n]) begin
               req_v[n] = ($urandom_range(0, 2) == 0);
               a[n] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom;
               b[n] = $urandom;
               c[n] = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) begin
               req_v[n] = 1'b0;
            end
            rsp_r[n] = ($urandom_range(0, 2) != 0);
         end
      end
      req_v = '0; rsp_r = 2'b11;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("drain_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters (Req0, Req1) with valid/ready request and response channels.
- Round-robin arbitration; operands and control are registered before driving the ALU, and the result is registered and held until the owning requester accepts it.
- Sits between the requesters and the ALU instance. It drives the ALU's SrcAE/SrcBE/ALUControl inputs and samples its Result.

Parameters:
- WIDTH, 32, operand/result width.
- CTRLW, 3, ALU control code width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Req0Valid  input  1  requester 0 has an operation.
- Req0Ready  output  1  requester 0 operation accepted this cycle.
- Req0SrcA  input  WIDTH  requester 0 operand A.
- Req0SrcB  input  WIDTH  requester 0 operand B.
- Req0Ctrl  input  CTRLW  requester 0 ALU control code.
- Req1Valid, Req1Ready, Req1SrcA, Req1SrcB, Req1Ctrl: same as above, for requester 1.
- Rsp0Valid  output  1  result available for requester 0.
- Rsp0Ready  input  1  requester 0 takes the result.
- Rsp0Result  output  WIDTH  result for requester 0.
- Rsp1Valid, Rsp1Ready, Rsp1Result: same as above, for requester 1.
- AluSrcA  output  WIDTH  to ALU SrcAE.
- AluSrcB  output  WIDTH  to ALU SrcBE.
- AluControl  output  CTRLW  to ALU ALUControl.
- AluResult  input  WIDTH  from ALU Result.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, Prio=0, Owner=0; operand/ctrl/result registers =0; all Ready/Valid outputs =0; Busy=0; AluSrcA/B/Control =0.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant rules:
  - Only one request valid: that requester wins.
  - Both valid: requester indexed by Prio wins.
- IDLE, accept:
  - ReqNReady is combinational: high only for the winner, only in IDLE, and only when its ReqNValid=1.
  - The loser's Ready stays 0.
  - On handshake: latch SrcA, SrcB, Ctrl into registers; Owner<=winner; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - Registered operands drive AluSrcA/B/Control.
  - Result register <= AluResult at the clock edge; go to RESP.
- RESP:
  - RspNValid=1 for Owner only; RspNResult = result register, stable while waiting.
  - On RspNReady=1: Prio<=~Owner; go to IDLE.
  - Backpressure holds RESP indefinitely. No new request is accepted in RESP or EXEC.
- Latency: accept at edge k, RspValid high from cycle k+2. Minimum 3 cycles per operation.
- ALU inputs hold their last registered values outside EXEC (no toggling while idle).
- RspNResult for the non-owner is 0.
- Control codes are passed through unmodified. Unsupported codes (100, 101, 111) return whatever the ALU yields, i.e. 0.
- Requesters must hold Valid and operands stable until Ready. Dropping Valid before Ready withdraws the request, with no side effects.
- Simultaneous events:
  - Both requests arrive in the same cycle: only one Ready is asserted.
  - The loser is served next, provided it keeps Valid high, because Prio flips after the winner's response.
  - A new request arriving during RESP waits until IDLE.
- Reset mid-operation (any state): the in-flight op is discarded, no response is issued, and everything returns to reset values immediately.

Test Plan:
1. Reset, then Req0 alone with Ctrl=001, A=0x0F0F0000, B=0x0000F0F0 -> Req0Ready in the acceptance cycle; Rsp0Valid 2 cycles later with Rsp0Result=0x0F0FF0F0; Rsp1Valid stays 0.
2. Req0 and Req1 valid in the same cycle after reset.
   - Req0: Ctrl=010, A=4, B=1. Req1: Ctrl=110, A=3, B=5.
   - Expected: Req0 is granted first with result 0x00000010; Req1 is granted next with Rsp1Result=0x00000001.
   - Expected: a second simultaneous pair grants Req1 first.
3. Response backpressure: Req1 with Ctrl=000, B=0x00001234, Rsp1Ready held low 5 cycles -> Rsp1Valid stays high and Rsp1Result stays 0x12340000 throughout; Req0 is not accepted (Req0Ready=0) until the cycle after Rsp1Ready=1.
4. Back-to-back from Req0 with Ctrl=011, A=8, B=0xFF00, Rsp0Ready tied high -> result 0x000000FF; one op accepted every 3 cycles; Busy is low only in acceptance-eligible cycles.
5. Illegal code: Req1 with Ctrl=101, A=1, B=2 -> Rsp1Result=0x00000000, normal handshake.
6. Assert rst_n low during EXEC of a Req0 op -> all outputs 0 asynchronously; after release no Rsp0Valid appears; the next Req1 request is granted normally.
